// File: rtl/pman_pkg.sv
// Shared button map and vector type for the Pac-Man button path and position controller.
package pman_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_MID   = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_DOWN  = 4;

  localparam int N_BTN = 5;

  // 10 ms at the 148.5 MHz pixel clock; the counter must reach DEBOUNCE_CYC-1.
  localparam int DEBOUNCE_CYC_DEFAULT = 1_485_000;
  localparam int CNT_W_DEFAULT        = 21;

  typedef logic [N_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/pman_debounce.sv
// One push-button: synchronizer chain, debounce qualification counter,
// debounced level and a single-cycle press pulse on each accepted rising level.
module pman_debounce
  import pman_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic clk_pix,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic [CNT_W-1:0]       cnt;

  // Plain flop chain; nothing may sit between the synchronizer stages.
  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // A new level is accepted only after it persists DEBOUNCE_CYC consecutive
  // cycles; any return to the current level restarts the count from zero.
  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (btn_s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_TERM) begin
        cnt       <= '0;
        btn_level <= btn_s;
        press_evt <= btn_s;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pman_btn_cond.sv
// Button conditioning for the Pac-Man position controller: per-button debounce,
// press latching between frames, opposing-pair cancellation and a frame-stable move vector.
module pman_btn_cond
  import pman_pkg::*;
#(
  parameter int N_BTN        = pman_pkg::N_BTN,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter bit HOLD_REPEAT  = 1'b1
) (
  input  logic             clk_pix,
  input  logic             rstn,
  input  logic             frame_tick,
  input  logic             game_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_evt,
  output logic [N_BTN-1:0] btn_pulse
);

  logic [N_BTN-1:0] sticky;
  logic [N_BTN-1:0] hold_vec;
  logic [N_BTN-1:0] raw_vec;
  logic [N_BTN-1:0] resolved;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    pman_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_debounce (
      .clk_pix   (clk_pix),
      .rstn      (rstn),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .press_evt (press_evt[i])
    );
  end

  assign hold_vec = HOLD_REPEAT ? btn_level : '0;

  // A press arriving in the capture cycle itself still counts for this frame.
  assign raw_vec = sticky | press_evt | hold_vec;

  always_comb begin
    resolved = raw_vec;
    if (raw_vec[BTN_UP] && raw_vec[BTN_DOWN]) begin
      resolved[BTN_UP]   = 1'b0;
      resolved[BTN_DOWN] = 1'b0;
    end
    if (raw_vec[BTN_LEFT] && raw_vec[BTN_RIGHT]) begin
      resolved[BTN_LEFT]  = 1'b0;
      resolved[BTN_RIGHT] = 1'b0;
    end
  end

  // Presses accumulate until the next frame boundary; game_reset outranks the frame tick.
  always_ff @(posedge clk_pix or negedge rstn) begin
    if (!rstn) begin
      sticky    <= '0;
      btn_pulse <= '0;
    end else if (game_reset) begin
      sticky    <= '0;
      btn_pulse <= '0;
    end else if (frame_tick) begin
      sticky    <= '0;
      btn_pulse <= resolved;
    end else begin
      sticky <= sticky | press_evt;
    end
  end

endmodule
